// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NUM_REQ requesters.
// Its single registered response slot is tagged with the id of the requester that issued it.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    CMD_ADD = 4'd0,
    CMD_SUB = 4'd1,
    CMD_AND = 4'd2,
    CMD_OR  = 4'd3,
    CMD_XOR = 4'd4,
    CMD_SLL = 4'd5,
    CMD_SRL = 4'd6,
    CMD_SRA = 4'd7,
    CMD_EQ  = 4'd8,
    CMD_NE  = 4'd9,
    CMD_LT  = 4'd10,
    CMD_LTU = 4'd11,
    CMD_GE  = 4'd12,
    CMD_GEU = 4'd13
  } command_t;

  // Full 32-bit shift amounts are used, so shifts by 32 or more drain to 0 (or to the sign).
  function automatic logic [31:0] alu(input logic [3:0]  cmd,
                                      input logic [31:0] lhs,
                                      input logic [31:0] rhs);
    logic [31:0] res;
    res = '0;
    case (cmd)
      CMD_ADD: res = lhs + rhs;
      CMD_SUB: res = lhs - rhs;
      CMD_AND: res = lhs & rhs;
      CMD_OR:  res = lhs | rhs;
      CMD_XOR: res = lhs ^ rhs;
      CMD_SLL: res = lhs << rhs;
      CMD_SRL: res = lhs >> rhs;
      CMD_SRA: res = $signed(lhs) >>> rhs;
      CMD_EQ:  res = {31'b0, lhs == rhs};
      CMD_NE:  res = {31'b0, lhs != rhs};
      CMD_LT:  res = {31'b0, $signed(lhs) < $signed(rhs)};
      CMD_LTU: res = {31'b0, lhs < rhs};
      CMD_GE:  res = {31'b0, $signed(lhs) >= $signed(rhs)};
      CMD_GEU: res = {31'b0, lhs >= rhs};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_command,
  input  logic [32*NUM_REQ-1:0] req_lhs,
  input  logic [32*NUM_REQ-1:0] req_rhs,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  input  logic                  resp_ready,
  output logic [15:0]           grant_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [15:0] grant_count_q, grant_count_d;

  logic            slot_free;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            accept;
  logic [3:0]      sel_cmd;
  logic [31:0]     sel_lhs;
  logic [31:0]     sel_rhs;
  logic [31:0]     alu_result;

  // Walk the ring from the far end back to ptr so the last hit is the nearest requester.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign slot_free = (state_q == EMPTY) || resp_ready;
  assign accept    = slot_free && grant_found;

  always_comb begin
    req_ready = '0;
    if (reset_n && accept) req_ready[grant_idx] = 1'b1;
  end

  assign sel_cmd    = req_command[4*grant_idx +: 4];
  assign sel_lhs    = req_lhs[32*grant_idx +: 32];
  assign sel_rhs    = req_rhs[32*grant_idx +: 32];
  assign alu_result = alu(sel_cmd, sel_lhs, sel_rhs);

  // A new accept overrides a same-cycle drain, so back-to-back results leave no bubble.
  always_comb begin
    state_d       = state_q;
    resp_id_d     = resp_id_q;
    resp_data_d   = resp_data_q;
    ptr_d         = ptr_q;
    grant_count_d = grant_count_q;
    if (accept) begin
      state_d       = FULL;
      resp_id_d     = grant_idx;
      resp_data_d   = alu_result;
      ptr_d         = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      grant_count_d = grant_count_q + 16'd1;
    end else if ((state_q == FULL) && resp_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= EMPTY;
      resp_id_q     <= '0;
      resp_data_q   <= '0;
      ptr_q         <= '0;
      grant_count_q <= '0;
    end else begin
      state_q       <= state_d;
      resp_id_q     <= resp_id_d;
      resp_data_q   <= resp_data_d;
      ptr_q         <= ptr_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign resp_valid  = (state_q == FULL);
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign grant_count = grant_count_q;

endmodule
